// File: rtl/run_control.sv
// rtl/run_control.sv - annealing run sequencer: N x (optimisation phase, replica-exchange phase)
// Optional macro RUN_CTRL_PARITY_ALT_EN: alternate exch_parity even/odd per iteration.
module run_control #(
  parameter int RUN_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_write,
  input  logic [RUN_W-1:0] run_times,
  output logic             opt_start,
  input  logic             opt_done,
  output logic             exch_start,
  input  logic             exch_done,
  output logic             exch_parity,
  output logic             running,
  output logic [RUN_W-1:0] iter_count,
  output logic             run_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPT  = 2'd1,
    S_EXCH = 2'd2
  } state_t;

  localparam logic [RUN_W-1:0] ONE = {{(RUN_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [RUN_W-1:0] remaining_q, remaining_d;
  logic [RUN_W-1:0] iter_count_q, iter_count_d;
  logic             stop_req_q, stop_req_d;
  logic             opt_start_q, opt_start_d;
  logic             exch_start_q, exch_start_d;
  logic             run_done_q, run_done_d;

  logic start_cmd;
  logic stop_cmd;

  assign start_cmd = run_write && (run_times != '0);
  assign stop_cmd  = run_write && (run_times == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      iter_count_q <= '0;
      stop_req_q   <= 1'b0;
      opt_start_q  <= 1'b0;
      exch_start_q <= 1'b0;
      run_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      iter_count_q <= iter_count_d;
      stop_req_q   <= stop_req_d;
      opt_start_q  <= opt_start_d;
      exch_start_q <= exch_start_d;
      run_done_q   <= run_done_d;
    end
  end

  // Start pulses are registered so they coincide with the first cycle of their state.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    iter_count_d = iter_count_q;
    stop_req_d   = stop_req_q;
    opt_start_d  = 1'b0;
    exch_start_d = 1'b0;
    run_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_cmd) begin
          state_d      = S_OPT;
          remaining_d  = run_times;
          iter_count_d = '0;
          stop_req_d   = 1'b0;
          opt_start_d  = 1'b1;
        end
      end
      S_OPT: begin
        if (stop_cmd) begin
          stop_req_d = 1'b1;
        end
        if (opt_done) begin
          state_d      = S_EXCH;
          exch_start_d = 1'b1;
        end
      end
      S_EXCH: begin
        if (stop_cmd) begin
          stop_req_d = 1'b1;
        end
        if (exch_done) begin
          if (iter_count_q != '1) begin
            iter_count_d = iter_count_q + ONE;
          end
          remaining_d = remaining_q - ONE;
          // A stop arriving with the final exch_done still ends the run here.
          if ((remaining_q == ONE) || stop_req_q || stop_cmd) begin
            state_d    = S_IDLE;
            stop_req_d = 1'b0;
            run_done_d = 1'b1;
          end else begin
            state_d     = S_OPT;
            opt_start_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef RUN_CTRL_PARITY_ALT_EN
  // par_next tracks the parity for the upcoming exchange; the output only moves on EXCH entry.
  logic par_next_q, par_next_d;
  logic exch_parity_q, exch_parity_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_next_q    <= 1'b0;
      exch_parity_q <= 1'b0;
    end else begin
      par_next_q    <= par_next_d;
      exch_parity_q <= exch_parity_d;
    end
  end

  always_comb begin
    par_next_d    = par_next_q;
    exch_parity_d = exch_parity_q;
    if ((state_q == S_IDLE) && start_cmd) begin
      par_next_d    = 1'b0;
      exch_parity_d = 1'b0;
    end else if ((state_q == S_OPT) && opt_done) begin
      exch_parity_d = par_next_q;
    end else if ((state_q == S_EXCH) && exch_done) begin
      par_next_d = ~par_next_q;
    end
  end

  assign exch_parity = exch_parity_q;
`else
  assign exch_parity = 1'b0;
`endif

  assign opt_start  = opt_start_q;
  assign exch_start = exch_start_q;
  assign run_done   = run_done_q;
  assign iter_count = iter_count_q;
  assign running    = (state_q != S_IDLE);

endmodule

// File: tb/tb_run_control.sv
// tb/tb_run_control.sv - randomized self-checking bench for run_control against an iteration-count model
module tb_run_control;

  localparam int RUN_W = 24;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run_write = 1'b0;
  logic [RUN_W-1:0] run_times = '0;
  logic             opt_start;
  logic             opt_done = 1'b0;
  logic             exch_start;
  logic             exch_done = 1'b0;
  logic             exch_parity;
  logic             running;
  logic [RUN_W-1:0] iter_count;
  logic             run_done;

  int checks = 0;
  int failures = 0;

  // Observations of the most recent run, filled by drive_run.
  int obs_opt, obs_exch, obs_done, obs_iter, obs_run_len;
  int obs_first_opt_cyc, obs_lat_bad, obs_running_bad, obs_extra;
  bit obs_timeout, obs_running_after;
  int obs_par[$];

  run_control #(.RUN_W(RUN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run_write  (run_write),
    .run_times  (run_times),
    .opt_start  (opt_start),
    .opt_done   (opt_done),
    .exch_start (exch_start),
    .exch_done  (exch_done),
    .exch_parity(exch_parity),
    .running    (running),
    .iter_count (iter_count),
    .run_done   (run_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_par(input int idx);
`ifdef RUN_CTRL_PARITY_ALT_EN
    return idx % 2;
`else
    return 0;
`endif
  endfunction

  // Starts a run of n iterations and acts as the node array; records everything seen.
  task automatic drive_run(input int n, input int opt_lat, input int exch_lat,
                           input int stop_iter, input int reload_iter, input bit stray);
    int opt_t, ex_t, last_ex, cyc;
    bit done_seen;
    obs_opt = 0; obs_exch = 0; obs_done = 0; obs_iter = -1; obs_run_len = -1;
    obs_first_opt_cyc = -1; obs_lat_bad = 0; obs_running_bad = 0; obs_extra = 0;
    obs_timeout = 1'b0; obs_running_after = 1'b0;
    obs_par.delete();
    opt_t = -1; ex_t = -1; last_ex = -100; done_seen = 1'b0;
    run_write = 1'b1;
    run_times = RUN_W'(n);
    opt_done = 1'b0;
    exch_done = 1'b0;
    for (cyc = 1; cyc < 600 && !done_seen; cyc++) begin
      step();
      run_write = 1'b0;
      opt_done = 1'b0;
      exch_done = 1'b0;
      if (opt_start) begin
        obs_opt++;
        if (obs_first_opt_cyc < 0) obs_first_opt_cyc = cyc;
        else if (cyc != last_ex + 1) obs_lat_bad++;
        opt_t = opt_lat;
        if (obs_opt == stop_iter) begin
          run_write = 1'b1;
          run_times = '0;
        end
        if (obs_opt == reload_iter) begin
          run_write = 1'b1;
          run_times = RUN_W'($urandom_range(1, 1000));
        end
        if (stray) exch_done = 1'b1;
      end
      if (exch_start) begin
        obs_exch++;
        obs_par.push_back(int'(exch_parity));
        ex_t = exch_lat;
        if (stray) opt_done = 1'b1;
      end
      if (run_done) begin
        done_seen = 1'b1;
        obs_done++;
        obs_iter = int'(iter_count);
        obs_run_len = cyc - obs_first_opt_cyc;
        if (cyc != last_ex + 1) obs_lat_bad++;
        if (running !== 1'b0) obs_running_bad++;
      end else if (running !== 1'b1) begin
        obs_running_bad++;
      end
      if (opt_t == 0) begin opt_done = 1'b1; opt_t = -1; end
      else if (opt_t > 0) opt_t--;
      if (ex_t == 0) begin exch_done = 1'b1; last_ex = cyc; ex_t = -1; end
      else if (ex_t > 0) ex_t--;
    end
    if (!done_seen) obs_timeout = 1'b1;
    opt_done = 1'b0;
    exch_done = 1'b0;
    run_write = 1'b0;
    // Quiet period with stray done pulses: nothing may start or finish again.
    for (int i = 0; i < 6; i++) begin
      opt_done = i[0];
      exch_done = ~i[0];
      step();
      if (opt_start || exch_start || run_done) obs_extra++;
      if (running) obs_running_after = 1'b1;
      if (done_seen && int'(iter_count) != obs_iter) obs_extra++;
    end
    opt_done = 1'b0;
    exch_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({opt_start, exch_start, exch_parity, running, run_done, iter_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {opt_start, exch_start, exch_parity, running, run_done, iter_count});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    drive_run(3, 2, 2, 0, 0, 1'b0);
    checks++;
    if (obs_timeout) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++;
    if (obs_opt != 3 || obs_exch != 3) begin
      failures++; $display("FAIL basic_starts got=%0d/%0d exp=3/3", obs_opt, obs_exch);
    end
    checks++;
    if (obs_iter != 3) begin failures++; $display("FAIL basic_iter got=%0d exp=3", obs_iter); end
    checks++;
    if (obs_done != 1 || obs_extra != 0) begin
      failures++; $display("FAIL basic_done got=%0d extra=%0d exp=1 extra=0", obs_done, obs_extra);
    end
    checks++;
    if (obs_first_opt_cyc != 1) begin
      failures++; $display("FAIL basic_start_latency got=%0d exp=1", obs_first_opt_cyc);
    end
    checks++;
    if (obs_running_bad != 0 || obs_running_after) begin
      failures++; $display("FAIL basic_running got=%0d after=%0d exp=0 after=0",
                           obs_running_bad, obs_running_after);
    end
  endtask

  task automatic test_zero_idle();
    int bad = 0;
    run_write = 1'b1;
    run_times = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      run_write = 1'b0;
      opt_done = i[0];
      exch_done = i[1];
      if (running || opt_start || exch_start || run_done) bad++;
    end
    opt_done = 1'b0;
    exch_done = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL zero_idle_activity got=%0d exp=0", bad); end
    checks++;
    if (iter_count !== RUN_W'(3)) begin
      failures++; $display("FAIL zero_idle_iter_hold got=%0d exp=3", iter_count);
    end
  endtask

  task automatic test_stop();
    drive_run(5, 2, 1, 2, 0, 1'b0);
    checks++;
    if (obs_timeout || obs_iter != 2 || obs_opt != 2 || obs_exch != 2) begin
      failures++; $display("FAIL stop_iter got=%0d starts=%0d/%0d exp=2", obs_iter, obs_opt, obs_exch);
    end
    checks++;
    if (obs_done != 1 || obs_extra != 0 || obs_running_after) begin
      failures++; $display("FAIL stop_done got=%0d extra=%0d exp=1 extra=0", obs_done, obs_extra);
    end
  endtask

  task automatic test_ignore_reload();
    drive_run(4, 1, 2, 0, 2, 1'b0);
    checks++;
    if (obs_timeout || obs_iter != 4 || obs_opt != 4 || obs_done != 1) begin
      failures++; $display("FAIL reload_iter got=%0d starts=%0d done=%0d exp=4/4/1",
                           obs_iter, obs_opt, obs_done);
    end
  endtask

  task automatic test_back_to_back();
    drive_run(2, 0, 0, 0, 0, 1'b0);
    checks++;
    if (obs_timeout || obs_run_len != 4) begin
      failures++; $display("FAIL b2b_run_len got=%0d exp=4", obs_run_len);
    end
    checks++;
    if (obs_iter != 2 || obs_lat_bad != 0) begin
      failures++; $display("FAIL b2b_iter got=%0d latbad=%0d exp=2 latbad=0", obs_iter, obs_lat_bad);
    end
  endtask

  task automatic test_parity();
    int bad = 0;
    drive_run(4, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i >= obs_par.size() || obs_par[i] != exp_par(i)) bad++;
    end
    checks++;
    if (bad != 0 || obs_par.size() != 4) begin
      failures++; $display("FAIL parity_seq got=%0d wrong of %0d exp=0 of 4", bad, obs_par.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    bit seen = 1'b0;
    run_write = 1'b1;
    run_times = RUN_W'(3);
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      run_write = 1'b0;
      opt_done = opt_start;
      if (exch_start) seen = 1'b1;
    end
    opt_done = 1'b0;
    checks++;
    if (!seen) begin failures++; $display("FAIL rst_mid_reach_exch got=0 exp=1"); end
    reset = 1'b1;
    step();
    checks++;
    if ({opt_start, exch_start, exch_parity, running, run_done, iter_count} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=0",
                           {opt_start, exch_start, exch_parity, running, run_done, iter_count});
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exch_done = i[0];
      step();
      if (run_done || running || opt_start || exch_start) bad++;
    end
    exch_done = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_mid_after got=%0d exp=0", bad); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      int n, ol, el, mode, stop_it, reload_it, exp_it, pbad;
      bit stray;
      n = $urandom_range(1, 6);
      ol = $urandom_range(0, 3);
      el = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      stray = 1'($urandom_range(0, 1));
      stop_it = (mode == 1) ? $urandom_range(1, n + 1) : 0;
      reload_it = (mode == 2) ? $urandom_range(1, n) : 0;
      exp_it = (stop_it > 0 && stop_it < n) ? stop_it : n;
      drive_run(n, ol, el, stop_it, reload_it, stray);
      pbad = 0;
      for (int i = 0; i < obs_par.size(); i++) if (obs_par[i] != exp_par(i)) pbad++;
      checks++;
      if (obs_timeout || obs_iter != exp_it || obs_opt != exp_it || obs_exch != exp_it) begin
        failures++; $display("FAIL rand%0d_iters got=%0d starts=%0d/%0d exp=%0d (n=%0d stop=%0d)",
                             r, obs_iter, obs_opt, obs_exch, exp_it, n, stop_it);
      end
      checks++;
      if (obs_run_len != exp_it * (ol + el + 2) || obs_lat_bad != 0) begin
        failures++; $display("FAIL rand%0d_timing got=%0d latbad=%0d exp=%0d latbad=0",
                             r, obs_run_len, obs_lat_bad, exp_it * (ol + el + 2));
      end
      checks++;
      if (obs_done != 1 || obs_extra != 0 || obs_running_bad != 0 || obs_running_after || pbad != 0) begin
        failures++; $display("FAIL rand%0d_status got=done%0d extra%0d runbad%0d after%0d par%0d exp=1/0/0/0/0",
                             r, obs_done, obs_extra, obs_running_bad, obs_running_after, pbad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_idle();
    test_stop();
    test_ignore_reload();
    test_back_to_back();
    test_parity();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
